project_switch_mux: RTL and testbench

// - Parametrised successor to the fixed 4-slot input/output project muxes; sits between mux_wrapper and NUM_PROJ projects.
// - Routes clk/rst_n/in to the selected project and its out back; unselected slots are clock-gated, held in reset, inputs zeroed.
// - Adds debounced selection and a sequenced drain -> reset -> release handover so projects never see a runt clock or partial reset.

---
 rtl/project_switch_mux_pkg.sv | 23 ++
 rtl/project_switch_mux_if.sv | 37 +++
 rtl/project_switch_mux_proj_clk_gate.sv | 22 ++
 rtl/project_switch_mux.sv | 207 ++++++++++++++++++++
 tb/tb_project_switch_mux.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/project_switch_mux_pkg.sv
// Shared definitions for the project switch mux and its neighbours.
// - state_e     : handover sequencer states
// - DEFAULT_*   : default slot count and widths, shared with mux_wrapper
// - cnt_width() : width of a counter that must hold values 0..max_val
package project_switch_mux_pkg;

    typedef enum logic [1:0] {
        StNone    = 2'd0,
        StRun     = 2'd1,
        StDrain   = 2'd2,
        StRelease = 2'd3
    } state_e;

    localparam int unsigned DEFAULT_NUM_PROJ    = 4;
    localparam int unsigned DEFAULT_SEL_BITS    = 2;
    localparam int unsigned DEFAULT_INPUT_BITS  = 12;
    localparam int unsigned DEFAULT_OUTPUT_BITS = 12;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/project_switch_mux_if.sv
// Bundle between mux_wrapper (master) and the project switch mux (slave).
// - sel        : requested project, asynchronous to clk
// - in / out   : shared project inputs / registered output of active project
// - proj_clk   : gated clock per slot
// - proj_rst_n : active-low reset per slot
// - proj_in    : per-slot inputs, slot i at [i*INPUT_BITS +: INPUT_BITS]
// - proj_out   : per-slot outputs, slot i at [i*OUTPUT_BITS +: OUTPUT_BITS]
// - active     : index of current/incoming project
// - busy       : high unless a project is running normally
interface project_switch_mux_if #(
    parameter int unsigned NUM_PROJ    = 4,
    parameter int unsigned SEL_BITS    = 2,
    parameter int unsigned INPUT_BITS  = 12,
    parameter int unsigned OUTPUT_BITS = 12
);

    logic [SEL_BITS-1:0]             sel;
    logic [INPUT_BITS-1:0]           in;
    logic [OUTPUT_BITS-1:0]          out;
    logic [NUM_PROJ-1:0]             proj_clk;
    logic [NUM_PROJ-1:0]             proj_rst_n;
    logic [NUM_PROJ*INPUT_BITS-1:0]  proj_in;
    logic [NUM_PROJ*OUTPUT_BITS-1:0] proj_out;
    logic [SEL_BITS-1:0]             active;
    logic                            busy;

    modport master (
        output sel, in, proj_out,
        input  out, proj_clk, proj_rst_n, proj_in, active, busy
    );

    modport slave (
        input  sel, in, proj_out,
        output out, proj_clk, proj_rst_n, proj_in, active, busy
    );

endinterface

// File: rtl/project_switch_mux_proj_clk_gate.sv
// Glitch-free clock gate for one project slot.
// - clk  : free-running clock
// - en   : enable, may change any time while clk is high
// - gclk : gated clock; the latch only follows en while clk is low, so an
//          enable change can never shorten or create a high phase.
module project_switch_mux_proj_clk_gate (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_latched;

    always_latch begin
        if (!clk) begin
            en_latched = en;
        end
    end

    assign gclk = clk & en_latched;

endmodule

// File: rtl/project_switch_mux.sv
// Routes clock, reset and inputs to one of NUM_PROJ project slots and muxes
// the selected slot's output back. Selection is synchronised and debounced,
// and every handover is sequenced drain -> reset -> release so a project
// never sees a runt clock or a partial reset.
// - clk, rst_n : single clock, asynchronous active-low reset
// - bus        : slave side of project_switch_mux_if (sel, in, out,
//                proj_clk, proj_rst_n, proj_in, proj_out, active, busy)
module project_switch_mux
    import project_switch_mux_pkg::*;
#(
    parameter int unsigned NUM_PROJ      = DEFAULT_NUM_PROJ,
    parameter int unsigned SEL_BITS      = DEFAULT_SEL_BITS,
    parameter int unsigned INPUT_BITS    = DEFAULT_INPUT_BITS,
    parameter int unsigned OUTPUT_BITS   = DEFAULT_OUTPUT_BITS,
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned DRAIN_CYCLES  = 2,
    parameter int unsigned RST_CYCLES    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    project_switch_mux_if.slave bus
);

    // One extra bit so "no project" (NUM_PROJ) is representable even when
    // NUM_PROJ == 2**SEL_BITS.
    localparam int unsigned TGT_BITS = SEL_BITS + 1;
    localparam int unsigned STABLE_W = cnt_width(STABLE_CYCLES);
    localparam int unsigned SEQ_MAX  = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
    localparam int unsigned SEQ_W    = cnt_width(SEQ_MAX);

    localparam logic [TGT_BITS-1:0] NO_PROJ     = TGT_BITS'(NUM_PROJ);
    localparam logic [STABLE_W-1:0] STABLE_MAX  = STABLE_W'(STABLE_CYCLES);
    localparam logic [SEQ_W-1:0]    DRAIN_LAST  = SEQ_W'(DRAIN_CYCLES - 1);
    localparam logic [SEQ_W-1:0]    RST_LAST    = SEQ_W'(RST_CYCLES - 1);

    // Selection synchroniser and debounce
    logic [SEL_BITS-1:0] sel_meta_q, sel_s_q;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [TGT_BITS-1:0] sel_ext;
    logic                sel_valid;
    logic                commit;

    // Sequencer
    state_e              state_q, state_d;
    logic [SEL_BITS-1:0] active_q, active_d;
    logic [TGT_BITS-1:0] target_q, target_d;
    logic [SEQ_W-1:0]    seq_cnt_q, seq_cnt_d;

    // Slot controls and output
    logic [NUM_PROJ-1:0]    rel_q, rel_d;
    logic [NUM_PROJ-1:0]    en;
    logic [OUTPUT_BITS-1:0] act_out;
    logic [OUTPUT_BITS-1:0] out_q, out_d;

    assign sel_ext   = {1'b0, sel_s_q};
    assign sel_valid = (sel_ext < NO_PROJ);

    // Counter restarts on the cycle sel_s is about to change and saturates
    // afterwards, so a request arriving mid-sequence is still seen on RUN entry.
    always_comb begin
        stable_cnt_d = stable_cnt_q;
        if (sel_meta_q != sel_s_q) begin
            stable_cnt_d = '0;
        end else if (stable_cnt_q != STABLE_MAX) begin
            stable_cnt_d = stable_cnt_q + 1'b1;
        end
    end

    assign commit = ((state_q == StRun) || (state_q == StNone)) &&
                    (stable_cnt_q == STABLE_MAX) && (sel_ext != target_q);

    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        target_d  = target_q;
        seq_cnt_d = seq_cnt_q;
        unique case (state_q)
            StNone: begin
                if (commit) begin
                    target_d = sel_ext;
                    if (sel_valid) begin
                        active_d  = sel_s_q;
                        seq_cnt_d = '0;
                        state_d   = StRelease;
                    end
                end
            end
            StRun: begin
                if (commit) begin
                    target_d  = sel_ext;
                    seq_cnt_d = '0;
                    state_d   = StDrain;
                end
            end
            StDrain: begin
                if (seq_cnt_q == DRAIN_LAST) begin
                    seq_cnt_d = '0;
                    if (target_q < NO_PROJ) begin
                        active_d = target_q[SEL_BITS-1:0];
                        state_d  = StRelease;
                    end else begin
                        state_d  = StNone;
                    end
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (seq_cnt_q == RST_LAST) begin
                    seq_cnt_d = '0;
                    state_d   = StRun;
                end else begin
                    seq_cnt_d = seq_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StNone;
            end
        endcase
    end

    // Local release is registered against the next state so it rises exactly
    // on the edge that enters RUN and drops on the edge that leaves it.
    always_comb begin
        rel_d = '0;
        if (state_d == StRun) begin
            for (int unsigned i = 0; i < NUM_PROJ; i++) begin
                rel_d[i] = (active_d == SEL_BITS'(i));
            end
        end
    end

    // Only one index can match active_q, so enables are one-hot or zero.
    always_comb begin
        en = '0;
        if (state_q != StNone) begin
            for (int unsigned i = 0; i < NUM_PROJ; i++) begin
                en[i] = (active_q == SEL_BITS'(i));
            end
        end
    end

    always_comb begin
        bus.proj_in = '0;
        if (state_q == StRun) begin
            for (int unsigned i = 0; i < NUM_PROJ; i++) begin
                if (active_q == SEL_BITS'(i)) begin
                    bus.proj_in[i*INPUT_BITS +: INPUT_BITS] = bus.in;
                end
            end
        end
    end

    always_comb begin
        act_out = '0;
        for (int unsigned i = 0; i < NUM_PROJ; i++) begin
            if (active_q == SEL_BITS'(i)) begin
                act_out = bus.proj_out[i*OUTPUT_BITS +: OUTPUT_BITS];
            end
        end
    end

    // Zero already on the edge that starts DRAIN, so out is 0 throughout it.
    assign out_d = ((state_q == StRun) && !commit) ? act_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_meta_q   <= '0;
            sel_s_q      <= '0;
            stable_cnt_q <= '0;
            state_q      <= StNone;
            active_q     <= '0;
            target_q     <= NO_PROJ;
            seq_cnt_q    <= '0;
            rel_q        <= '0;
            out_q        <= '0;
        end else begin
            sel_meta_q   <= bus.sel;
            sel_s_q      <= sel_meta_q;
            stable_cnt_q <= stable_cnt_d;
            state_q      <= state_d;
            active_q     <= active_d;
            target_q     <= target_d;
            seq_cnt_q    <= seq_cnt_d;
            rel_q        <= rel_d;
            out_q        <= out_d;
        end
    end

    for (genvar g = 0; g < NUM_PROJ; g++) begin : g_gate
        project_switch_mux_proj_clk_gate u_gate (
            .clk  (clk),
            .en   (en[g]),
            .gclk (bus.proj_clk[g])
        );
    end

    // rst_n gating makes slot resets assert in the same instant as the global reset.
    assign bus.proj_rst_n = rel_q & {NUM_PROJ{rst_n}};
    assign bus.out        = out_q;
    assign bus.active     = active_q;
    assign bus.busy       = (state_q != StRun);

    a_en_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(en));
    a_rel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rel_q));

endmodule

// File: tb/tb_project_switch_mux.sv
module tb_project_switch_mux;

    localparam int unsigned NP = 5;
    localparam int unsigned SB = 3;
    localparam int unsigned IB = 12;
    localparam int unsigned OB = 12;

    typedef struct {
        int              cyc;
        string           name;
        logic            busy;
        logic [SB-1:0]   active;
        logic [NP-1:0]   prst;
        logic [OB-1:0]   out;
        logic [NP*IB-1:0] pin;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pcyc = 0;
    int   pass_cnt = 0;
    int   tot_cnt = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    project_switch_mux_if #(
        .NUM_PROJ    (NP),
        .SEL_BITS    (SB),
        .INPUT_BITS  (IB),
        .OUTPUT_BITS (OB)
    ) bus ();

    project_switch_mux #(
        .NUM_PROJ      (NP),
        .SEL_BITS      (SB),
        .INPUT_BITS    (IB),
        .OUTPUT_BITS   (OB),
        .STABLE_CYCLES (4),
        .DRAIN_CYCLES  (2),
        .RST_CYCLES    (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tot_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Project models: slot i returns its input plus 0x111*(i+1).
    always_comb begin
        bus.proj_out = '0;
        for (int i = 0; i < NP; i++) begin
            bus.proj_out[i*OB +: OB] = bus.proj_in[i*IB +: IB] + OB'(12'h111 * (i + 1));
        end
    end

    for (genvar g = 0; g < NP; g++) begin : g_proj
        int  pulses = 0;
        time t_rise = 0;
        always @(posedge bus.proj_clk[g]) begin
            pulses <= pulses + 1;
            t_rise <= $time;
        end
        always @(negedge bus.proj_clk[g]) begin
            chk("clk_pulse_width", 64'($time - t_rise), 64'd5);
        end
    end

    always @(bus.proj_clk) begin
        chk("clk_onehot0", 64'($onehot0(bus.proj_clk)), 64'd1);
    end

    function automatic int pulse_sum();
        return g_proj[0].pulses + g_proj[1].pulses + g_proj[2].pulses +
               g_proj[3].pulses + g_proj[4].pulses;
    endfunction

    function automatic logic [NP*IB-1:0] pin_of(input int slot, input logic [IB-1:0] v);
        logic [NP*IB-1:0] r;
        r = '0;
        r[slot*IB +: IB] = v;
        return r;
    endfunction

    task automatic expect_at(input int d, input string name, input logic busy,
                             input logic [SB-1:0] act, input logic [NP-1:0] prst,
                             input logic [OB-1:0] out, input logic [NP*IB-1:0] pin);
        exp_t e;
        int   idx;
        e.cyc = pcyc + d;
        e.name = name;
        e.busy = busy;
        e.active = act;
        e.prst = prst;
        e.out = out;
        e.pin = pin;
        idx = sbq.size();
        while (idx > 0 && sbq[idx-1].cyc > e.cyc) idx--;
        sbq.insert(idx, e);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compares every expectation due on this cycle, 1 time unit after negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            while (sbq.size() > 0 && sbq[0].cyc <= pcyc) begin
                e = sbq.pop_front();
                if (e.cyc < pcyc) begin
                    chk({e.name, "_missed"}, 64'(pcyc), 64'(e.cyc));
                end else begin
                    chk({e.name, "_busy"},   64'(bus.busy),       64'(e.busy));
                    chk({e.name, "_active"}, 64'(bus.active),     64'(e.active));
                    chk({e.name, "_prst"},   64'(bus.proj_rst_n), 64'(e.prst));
                    chk({e.name, "_out"},    64'(bus.out),        64'(e.out));
                    chk({e.name, "_pin"},    64'(bus.proj_in),    64'(e.pin));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        bus.sel = 3'd1;
        bus.in  = 12'h010;
        wait_n(3);
        expect_at(1, "reset", 1'b1, 3'd0, 5'b00000, 12'h000, '0);
        wait_n(2);

        // Power-up selection of slot 1
        rst_n = 1'b1;
        expect_at(6,  "t1_debounce", 1'b1, 3'd1 - 3'd1, 5'b00000, 12'h000, '0);
        expect_at(7,  "t1_rel_start", 1'b1, 3'd1, 5'b00000, 12'h000, '0);
        expect_at(14, "t1_rel_end", 1'b1, 3'd1, 5'b00000, 12'h000, '0);
        expect_at(15, "t1_run", 1'b0, 3'd1, 5'b00010, 12'h000, pin_of(1, 12'h010));
        expect_at(16, "t1_out", 1'b0, 3'd1, 5'b00010, 12'h232, pin_of(1, 12'h010));
        wait_n(20);

        // Switch 1 -> 2
        bus.sel = 3'd2;
        expect_at(6,  "t2_pre", 1'b0, 3'd1, 5'b00010, 12'h232, pin_of(1, 12'h010));
        expect_at(7,  "t2_drain0", 1'b1, 3'd1, 5'b00000, 12'h000, '0);
        expect_at(8,  "t2_drain1", 1'b1, 3'd1, 5'b00000, 12'h000, '0);
        expect_at(9,  "t2_rel", 1'b1, 3'd2, 5'b00000, 12'h000, '0);
        expect_at(16, "t2_rel_end", 1'b1, 3'd2, 5'b00000, 12'h000, '0);
        expect_at(17, "t2_run", 1'b0, 3'd2, 5'b00100, 12'h000, pin_of(2, 12'h010));
        wait_n(18);
        bus.in = 12'hABC;
        expect_at(1, "t2_newin", 1'b0, 3'd2, 5'b00100, 12'hDEF, pin_of(2, 12'hABC));
        wait_n(2);

        // Short glitch 2 -> 3 -> 2 must not disturb slot 2
        p = g_proj[2].pulses;
        for (int d = 2; d <= 14; d += 4) begin
            expect_at(d, "t3_glitch", 1'b0, 3'd2, 5'b00100, 12'hDEF, pin_of(2, 12'hABC));
        end
        bus.sel = 3'd3;
        wait_n(2);
        bus.sel = 3'd2;
        wait_n(12);
        chk("t3_clk_continuous", 64'(g_proj[2].pulses - p), 64'd14);

        // Invalid selection 5: drain, then no project
        bus.sel = 3'd5;
        expect_at(7,  "t4_drain", 1'b1, 3'd2, 5'b00000, 12'h000, '0);
        expect_at(9,  "t4_none", 1'b1, 3'd2, 5'b00000, 12'h000, '0);
        expect_at(20, "t4_none_hold", 1'b1, 3'd2, 5'b00000, 12'h000, '0);
        wait_n(10);
        p = pulse_sum();
        wait_n(10);
        chk("t4_clk_quiet", 64'(pulse_sum() - p), 64'd0);

        // From no project to slot 0
        bus.sel = 3'd0;
        expect_at(6,  "t4_none_wait", 1'b1, 3'd2, 5'b00000, 12'h000, '0);
        expect_at(7,  "t4_rel0", 1'b1, 3'd0, 5'b00000, 12'h000, '0);
        expect_at(15, "t4_run0", 1'b0, 3'd0, 5'b00001, 12'h000, pin_of(0, 12'hABC));
        expect_at(16, "t4_out0", 1'b0, 3'd0, 5'b00001, 12'hBCD, pin_of(0, 12'hABC));
        wait_n(20);

        // New request while releasing slot 3: finish to RUN, then drain toward 4
        bus.sel = 3'd3;
        expect_at(7, "t5_drain", 1'b1, 3'd0, 5'b00000, 12'h000, '0);
        expect_at(9, "t5_rel3", 1'b1, 3'd3, 5'b00000, 12'h000, '0);
        wait_n(10);
        bus.sel = 3'd4;
        expect_at(7,  "t5_run3", 1'b0, 3'd3, 5'b01000, 12'h000, pin_of(3, 12'hABC));
        expect_at(8,  "t5_drain_next", 1'b1, 3'd3, 5'b00000, 12'h000, '0);
        expect_at(10, "t5_rel4", 1'b1, 3'd4, 5'b00000, 12'h000, '0);
        expect_at(18, "t5_run4", 1'b0, 3'd4, 5'b10000, 12'h000, pin_of(4, 12'hABC));
        expect_at(19, "t5_out4", 1'b0, 3'd4, 5'b10000, 12'h011, pin_of(4, 12'hABC));
        wait_n(22);

        // Reset asserted in the middle of RELEASE of slot 1
        bus.sel = 3'd1;
        expect_at(7, "t6_drain", 1'b1, 3'd4, 5'b00000, 12'h000, '0);
        expect_at(9, "t6_rel1", 1'b1, 3'd1, 5'b00000, 12'h000, '0);
        wait_n(12);
        rst_n = 1'b0;
        expect_at(0, "t6_rst_async", 1'b1, 3'd0, 5'b00000, 12'h000, '0);
        p = pulse_sum();
        wait_n(3);
        chk("t6_clk_quiet_rst", 64'(pulse_sum() - p), 64'd0);

        // Re-debounce after reset, then reset while running
        rst_n = 1'b1;
        expect_at(6,  "t7_none", 1'b1, 3'd0, 5'b00000, 12'h000, '0);
        expect_at(7,  "t7_rel1", 1'b1, 3'd1, 5'b00000, 12'h000, '0);
        expect_at(15, "t7_run1", 1'b0, 3'd1, 5'b00010, 12'h000, pin_of(1, 12'hABC));
        expect_at(16, "t7_out1", 1'b0, 3'd1, 5'b00010, 12'hCDE, pin_of(1, 12'hABC));
        wait_n(20);
        rst_n = 1'b0;
        expect_at(0, "t7_rst_run", 1'b1, 3'd0, 5'b00000, 12'h000, '0);
        wait_n(2);

        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
